// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: FSM state encoding and the 18-bit
// instruction field map used by both fetch and decode.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HALT
  } fetch_state_t;

  localparam int unsigned INSTR_W = 18;

  localparam int unsigned OPC_MSB = 17;
  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned RD_MSB  = 11;
  localparam int unsigned RD_LSB  = 8;
  localparam int unsigned RS1_MSB = 7;
  localparam int unsigned RS1_LSB = 4;
  localparam int unsigned RS2_MSB = 3;
  localparam int unsigned RS2_LSB = 0;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO for fetched words; DEPTH must be a power of two so the
// read/write pointers wrap naturally.
module fetch_fifo #(
  parameter  int unsigned WIDTH = 28,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !flush && (!full || pop);
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding imem requests, fetch FIFO,
// redirect and halt. Optional performance counters under FETCH_PERF_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 10,
  parameter int unsigned       DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               pc_src,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               finish,
  output logic               halted,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall
);

  localparam int unsigned ENTRY_W = INSTR_W + ADDR_W;
  localparam int unsigned CNT_W   = ((DEPTH > 1) ? $clog2(DEPTH) : 1) + 1;

  fetch_state_t state_q, state_d;

  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  req_addr_q;
  logic               outstanding_q;
  logic               stale_q;

  logic               in_fetch;
  logic               issue;
  logic               resp;
  logic               redirect;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_flush;
  logic [ENTRY_W-1:0] fifo_rdata;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic [INSTR_W-1:0] head_instr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   if (finish) state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // finish beats pc_src, which beats pop, which beats push
  assign in_fetch   = (state_q == FETCH);
  assign redirect   = in_fetch && pc_src && !finish;
  assign issue      = in_fetch && !outstanding_q && (fifo_count < CNT_W'(DEPTH))
                      && !pc_src && !finish;
  assign resp       = imem_valid && outstanding_q;
  assign fifo_push  = resp && !stale_q && in_fetch && !pc_src && !finish;
  assign fifo_flush = redirect || finish || (state_q == HALT);
  assign fifo_pop   = instr_valid && instr_ready && !pc_src && !finish;

  assign imem_req    = issue;
  assign imem_addr   = issue ? pc_q : '0;
  assign instr_valid = !fifo_empty && (state_q != HALT);
  assign halted      = (state_q == HALT);
  assign instr_pc    = instr_valid ? fifo_rdata[ADDR_W-1:0] : '0;
  assign head_instr  = fifo_rdata[ENTRY_W-1:ADDR_W];

  always_comb begin
    instruction = '0;
    if (instr_valid) begin
      instruction[OPC_MSB:OPC_LSB] = head_instr[OPC_MSB:OPC_LSB];
      instruction[RD_MSB:RD_LSB]   = head_instr[RD_MSB:RD_LSB];
      instruction[RS1_MSB:RS1_LSB] = head_instr[RS1_MSB:RS1_LSB];
      instruction[RS2_MSB:RS2_LSB] = head_instr[RS2_MSB:RS2_LSB];
    end
  end

  // A redirect with a response already on the bus drops it directly; only a
  // still-pending request needs the stale mark.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      req_addr_q    <= '0;
      outstanding_q <= 1'b0;
      stale_q       <= 1'b0;
    end else begin
      if (resp) begin
        outstanding_q <= 1'b0;
        stale_q       <= 1'b0;
      end
      if (issue) begin
        outstanding_q <= 1'b1;
        req_addr_q    <= pc_q;
        pc_q          <= pc_q + ADDR_W'(1);
      end
      if (redirect) begin
        pc_q <= branch_target;
        if (outstanding_q && !imem_valid) stale_q <= 1'b1;
      end
    end
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push && (!fifo_full || fifo_pop)),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .wdata ({imem_rdata, req_addr_q}),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else if (state_q != HALT) begin
      if (fifo_pop)                   perf_fetched <= perf_fetched + 32'd1;
      if (instr_valid && !instr_ready) perf_stall  <= perf_stall + 32'd1;
    end
  end
`else
  assign perf_fetched = '0;
  assign perf_stall   = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed phases push expected words, a
// negedge monitor compares every word accepted by decode.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic        imem_valid;
  logic [17:0] imem_rdata;
  logic [17:0] instruction;
  logic [9:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        pc_src = 1'b0;
  logic [9:0]  branch_target = '0;
  logic        finish = 1'b0;
  logic        halted;
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;

  logic        mem_valid = 1'b0;
  logic [17:0] mem_rdata = '0;
  logic        stray_valid = 1'b0;
  logic [17:0] stray_data = '0;
  assign imem_valid = mem_valid | stray_valid;
  assign imem_rdata = stray_valid ? stray_data : mem_rdata;

  // second instance exercising the PC wrap from RESET_PC=0x3FE
  logic        imem_req2;
  logic [9:0]  imem_addr2;
  logic        imem_valid2 = 1'b0;
  logic [17:0] imem_rdata2 = '0;
  logic [17:0] instruction2;
  logic [9:0]  instr_pc2;
  logic        instr_valid2;
  logic        halted2;
  logic [31:0] perf_fetched2;
  logic [31:0] perf_stall2;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [9:0]  pc;
    logic [17:0] data;
  } exp_t;
  exp_t exp_q[$];

  int          mem_lat = 1;
  int          mem_cnt = 0;
  logic        mem_pending = 1'b0;
  logic [9:0]  mem_paddr = '0;
  int          req_cnt = 0;
  logic [9:0]  last_req = '0;

  logic        seen2 = 1'b0;
  logic [9:0]  a2 = '0;
  logic [9:0]  log2 [3];
  int          n2 = 0;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(10), .DEPTH(2), .RESET_PC(10'h000)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .instruction(instruction),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc_src(pc_src), .branch_target(branch_target), .finish(finish),
    .halted(halted), .perf_fetched(perf_fetched), .perf_stall(perf_stall)
  );

  fetch_unit #(.ADDR_W(10), .DEPTH(2), .RESET_PC(10'h3FE)) dut2 (
    .clk(clk), .reset(reset), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_valid(imem_valid2), .imem_rdata(imem_rdata2), .instruction(instruction2),
    .instr_pc(instr_pc2), .instr_valid(instr_valid2), .instr_ready(1'b1),
    .pc_src(1'b0), .branch_target(10'h000), .finish(1'b0),
    .halted(halted2), .perf_fetched(perf_fetched2), .perf_stall(perf_stall2)
  );

  // memory: content is addr+0x100, latency mem_lat cycles, forgets on reset
  always @(negedge clk) begin
    mem_valid = 1'b0;
    if (!reset) begin
      mem_pending = 1'b0;
    end else begin
      if (mem_pending) begin
        if (mem_cnt == 0) begin
          mem_valid   = 1'b1;
          mem_rdata   = 18'h100 + 18'(mem_paddr);
          mem_pending = 1'b0;
        end else begin
          mem_cnt = mem_cnt - 1;
        end
      end
      if (imem_req) begin
        mem_pending = 1'b1;
        mem_cnt     = mem_lat - 1;
        mem_paddr   = imem_addr;
        req_cnt     = req_cnt + 1;
        last_req    = imem_addr;
      end
    end
  end

  always @(negedge clk) begin
    imem_valid2 = seen2;
    imem_rdata2 = 18'h100 + 18'(a2);
    seen2 = imem_req2;
    a2    = imem_addr2;
    if (imem_req2 && n2 < 3) begin
      log2[n2] = imem_addr2;
      n2 = n2 + 1;
    end
  end

  // monitor: every word decode accepts must match the scoreboard head
  always @(negedge clk) begin
    if (reset && instr_valid && instr_ready && !pc_src && !finish) begin
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        failures = failures + 1;
        $display("FAIL sb_unexpected: got pc=%0h instr=%0h, required no delivery", instr_pc, instruction);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (instr_pc !== e.pc || instruction !== e.data) begin
          failures = failures + 1;
          $display("FAIL sb_word: got pc=%0h instr=%0h, required pc=%0h instr=%0h",
                   instr_pc, instruction, e.pc, e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [9:0] pc, input logic [17:0] data);
    exp_q.push_back('{pc: pc, data: data});
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (exp_q.size() != 0 && n < 400);
    chk(name, exp_q.size(), 0);
    exp_q.delete();
    #1 instr_ready = 1'b0;
  endtask

  task automatic wait_req(input string name, input int after);
    int n = 0;
    while (req_cnt <= after && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk(name, 32'(req_cnt > after), 1);
  endtask

  initial begin
    int n;
    int rc;
    logic [31:0] pf;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_halted", halted, 0);

    // phase 1: streaming at latency 1
    push_exp(10'h000, 18'h100);
    push_exp(10'h001, 18'h101);
    push_exp(10'h002, 18'h102);
    push_exp(10'h003, 18'h103);
    reset = 1'b1;
    instr_ready = 1'b1;
    wait_drain("drain_stream");

    // phase 2: decode stalled for 10 cycles
    repeat (10) @(posedge clk);
    #1;
    chk("stall_req_cnt", req_cnt, 6);
    chk("stall_last_req", last_req, 10'h005);
    chk("stall_valid", instr_valid, 1);
    chk("stall_head_pc", instr_pc, 10'h004);
    chk("stall_head_instr", instruction, 18'h104);
`ifdef FETCH_PERF_EN
    chk("perf_fetched_4", perf_fetched, 4);
`else
    chk("perf_tied_off", perf_fetched | perf_stall, 0);
`endif

    // phase 3: release, then redirect while request 7 is outstanding
    push_exp(10'h004, 18'h104);
    push_exp(10'h005, 18'h105);
    push_exp(10'h006, 18'h106);
    mem_lat = 6;
    instr_ready = 1'b1;
    wait_drain("drain_release");
    n = 0;
    while (!(mem_pending && last_req == 10'h007) && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("req7_outstanding", 32'(mem_pending && last_req == 10'h007), 1);
    #1;
    pc_src = 1'b1;
    branch_target = 10'h040;
    mem_lat = 8;
    rc = req_cnt;
    @(posedge clk);
    #1;
    pc_src = 1'b0;
    chk("redir_valid", instr_valid, 0);
    chk("redir_no_req", imem_req, 0);
    push_exp(10'h040, 18'h140);
    push_exp(10'h041, 18'h141);
    instr_ready = 1'b1;
    wait_req("redir_req_seen", rc);
    chk("redir_target_addr", last_req, 10'h040);
    wait_drain("drain_redirect");

    // phase 4: asynchronous reset while a request is outstanding
    n = 0;
    while (!mem_pending && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("pending_before_reset", mem_pending, 1);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("areset_req", imem_req, 0);
    chk("areset_addr", imem_addr, 0);
    chk("areset_valid", instr_valid, 0);
    chk("areset_instr", instruction, 0);
    chk("areset_pc", instr_pc, 0);
    chk("areset_halted", halted, 0);
    chk("areset_perf", perf_fetched | perf_stall, 0);
    mem_lat = 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    stray_valid = 1'b1;
    stray_data = 18'h2ABCD;
    push_exp(10'h000, 18'h100);
    instr_ready = 1'b1;
    @(negedge clk);
    chk("idle_no_req", imem_req, 0);
    @(posedge clk);
    #1;
    stray_valid = 1'b0;
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 10'h000);
    wait_drain("drain_after_reset");

    // phase 5: finish and pc_src together
    repeat (8) @(posedge clk);
    #1;
    finish = 1'b1;
    pc_src = 1'b1;
    branch_target = 10'h100;
    pf = perf_fetched;
    rc = req_cnt;
    @(posedge clk);
    #1;
    finish = 1'b0;
    pc_src = 1'b0;
    chk("halt_flag", halted, 1);
    chk("halt_valid", instr_valid, 0);
    instr_ready = 1'b1;
    stray_valid = 1'b1;
    stray_data = 18'h15555;
    @(posedge clk);
    #1 stray_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("halt_no_req", req_cnt, rc);
    chk("halt_valid_late", instr_valid, 0);
    chk("halt_sticky", halted, 1);
    chk("halt_perf_frozen", perf_fetched, pf);

    chk("wrap_req_count", 32'(n2 >= 3), 1);
    chk("wrap_addr0", log2[0], 10'h3FE);
    chk("wrap_addr1", log2[1], 10'h3FF);
    chk("wrap_addr2", log2[2], 10'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
